// File: rtl/keypad_pkg.sv
// Shared register map, field positions and key-code geometry for the keypad scanner.
// Constants only; no timing or flow-control behaviour.
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int ROW_W      = 2;
    localparam int COL_W      = 2;

    // Word offsets, decoded from HADDR[3:2]
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STAT_OVF    = 7;
    localparam int STAT_FULL   = 6;
    localparam int STAT_EMPTY  = 5;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    // Index of the lowest set column bit; higher simultaneous columns lose.
    function automatic logic [COL_W-1:0] lowest_col(input logic [NUM_COLS-1:0] p);
        logic [COL_W-1:0] c;
        c = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (p[i]) c = COL_W'(i);
        end
        return c;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Synchronous key-code FIFO; dout shows the head combinationally, updates take one cycle.
// Backpressure: push when full is dropped unless a pop happens the same cycle; pop when empty is ignored.
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan_ahb.sv
// AHB-Lite keypad scanner: drives rows one-hot, queues {row,col} codes from debounced column pulses.
// Latency: zero-wait bus, push visible next cycle; backpressure: full FIFO drops keys and sets sticky overflow.
module keypad_scan_ahb
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 8192,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [3:0]          HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA,
    input  logic [NUM_COLS-1:0] key_pulse,
    output logic [NUM_ROWS-1:0] row,
    output logic                key_irq
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  act_q, wr_q;
    logic [1:0]            addr_q;
    logic [1:0]            ctrl_q, ctrl_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_q;
    logic [DW-1:0]         dwell_q;
    logic [ROW_W-1:0]      row_idx_q;

    logic                  enable, wr_ctrl, wr_stat, rd_data;
    logic                  key_vld, push_ok, pop_ok, nonempty_d;
    logic [KEY_CODE_W-1:0] key_dat, fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[1:0], HTRANS[0], HWDATA[31:8], HWDATA[6:2]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            act_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else if (HREADY) begin
            act_q  <= HSEL & HTRANS[1];
            wr_q   <= HWRITE;
            addr_q <= HADDR[3:2];
        end
    end

    assign wr_ctrl = act_q & wr_q & (addr_q == ADDR_CTRL);
    assign wr_stat = act_q & wr_q & (addr_q == ADDR_STATUS);
    assign rd_data = act_q & ~wr_q & (addr_q == ADDR_DATA);

    assign enable  = ctrl_q[CTRL_EN];
    assign key_vld = enable & (|key_pulse);
    assign key_dat = {row_idx_q, lowest_col(key_pulse)};

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_CODE_W)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (key_vld),
        .pop_i   (rd_data),
        .din_i   (key_dat),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pop_ok  = rd_data & ~fifo_empty;
    assign push_ok = key_vld & (~fifo_full | pop_ok);

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) ctrl_d = HWDATA[1:0];
        ovf_d = ovf_q;
        if (wr_stat && HWDATA[STAT_OVF]) ovf_d = 1'b0;
        // A fresh drop wins over a same-cycle clear so the loss is never hidden.
        if (key_vld && fifo_full && !pop_ok) ovf_d = 1'b1;
        nonempty_d = push_ok | (~fifo_empty & ~(pop_ok & (fifo_count == CW'(1))));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_q <= '0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            irq_q  <= ctrl_d[CTRL_IRQ_EN] & nonempty_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dwell_q   <= '0;
            row_idx_q <= '0;
        end else if (!enable) begin
            dwell_q   <= '0;
            row_idx_q <= '0;
        end else if (dwell_q == DW'(SCAN_DIV - 1)) begin
            dwell_q   <= '0;
            row_idx_q <= row_idx_q + ROW_W'(1);
        end else begin
            dwell_q   <= dwell_q + DW'(1);
        end
    end

    assign row     = enable ? (NUM_ROWS'(1) << row_idx_q) : '0;
    assign key_irq = irq_q;

    always_comb begin
        HRDATA = '0;
        if (act_q && !wr_q) begin
            case (addr_q)
                ADDR_DATA:   if (!fifo_empty) HRDATA = {{(31 - KEY_CODE_W){1'b0}}, 1'b1, fifo_dout};
                ADDR_STATUS: HRDATA = {24'b0, ovf_q, fifo_full, fifo_empty, 5'(fifo_count)};
                ADDR_CTRL:   HRDATA = {30'b0, ctrl_q};
                default:     HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ahb.sv
// Randomized self-checking bench for keypad_scan_ahb against a queue/arithmetic reference model.
module tb_keypad_scan_ahb;

    localparam int SCAN_DIV = 8192;
    localparam int DEPTH    = 4;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
    logic [3:0]  HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic [3:0]  key_pulse = '0;
    logic [3:0]  row;
    logic        key_irq;

    keypad_scan_ahb #(.SCAN_DIV(SCAN_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .key_pulse(key_pulse), .row(row), .key_irq(key_irq)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    // Reference model: queue of codes, sticky overflow, control bits, scan start cycle.
    int q[$];
    bit m_ovf = 0, m_en = 0, m_irq_en = 0;
    int t_en = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int exp_row_idx(int k);
        return ((k - t_en) / SCAN_DIV) % 4;
    endfunction

    function automatic logic [3:0] exp_row(int k);
        return m_en ? 4'(1 << exp_row_idx(k)) : 4'h0;
    endfunction

    function automatic int lowest(logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[7]   = m_ovf;
        s[6]   = (q.size() == DEPTH);
        s[5]   = (q.size() == 0);
        s[4:0] = 5'(q.size());
        return s;
    endfunction

    function automatic void model_push(logic [3:0] p, int k);
        if (m_en && p != 0) begin
            if (q.size() < DEPTH) q.push_back(exp_row_idx(k) * 4 + lowest(p));
            else m_ovf = 1;
        end
    endfunction

    task automatic wait_cyc(int t);
        while (cyc < t) begin
            @(posedge HCLK); #1;
        end
    endtask

    task automatic bus_write(logic [3:0] a, logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = 1;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 0; HWRITE = 0; HWDATA = d;
        if (a[3:2] == 2'd2) begin
            if (d[0] && !m_en) t_en = cyc + 1;
            m_en = d[0];
            m_irq_en = d[1];
        end
        if (a[3:2] == 2'd1 && d[7]) m_ovf = 0;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_read(logic [3:0] a, output logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = 0;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 0;
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic chk_read(string tag, logic [3:0] a);
        logic [31:0] exp, got;
        case (a[3:2])
            2'd0:    exp = (q.size() > 0) ? (32'h10 | 32'(q.pop_front())) : 32'h0;
            2'd1:    exp = exp_status();
            2'd2:    exp = {30'b0, m_irq_en, m_en};
            default: exp = 32'h0;
        endcase
        bus_read(a, got);
        chk(tag, got, exp);
    endtask

    task automatic pulse(logic [3:0] p);
        key_pulse = p;
        model_push(p, cyc);
        @(posedge HCLK); #1;
        key_pulse = 0;
    endtask

    task automatic chk_row_at(int t);
        wait_cyc(t);
        @(negedge HCLK);
        chk("row", 32'(row), 32'(exp_row(cyc)));
    endtask

    task automatic chk_state(string tag);
        @(negedge HCLK);
        chk({tag, "_row"}, 32'(row), 32'(exp_row(cyc)));
        chk({tag, "_irq"}, 32'(key_irq), 32'(m_irq_en && q.size() > 0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_row", 32'(row), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_irq", 32'(key_irq), 32'h0);
        #3 HRESETn = 1;
        chk("hreadyout", 32'(HREADYOUT), 32'h1);
        chk("hresp", 32'(HRESP), 32'h0);
        chk_read("rst_status", 4'h4);
        chk_read("rst_ctrl", 4'h8);
        chk_read("rst_data", 4'h0);

        // Row rotation, boundary pulse, row-2 capture, wrap, disabled pulse
        bus_write(4'h8, 32'h1);
        chk_row_at(t_en);
        chk_row_at(t_en + SCAN_DIV - 1);
        pulse(4'b0001);
        chk_row_at(t_en + SCAN_DIV);
        chk_read("adv_data", 4'h0);
        chk_row_at(t_en + 2 * SCAN_DIV);
        pulse(4'b0100);
        chk_read("r2_status", 4'h4);
        chk_read("r2_data", 4'h0);
        chk_read("r2_status_empty", 4'h4);
        chk_row_at(t_en + 3 * SCAN_DIV);
        chk_row_at(t_en + 4 * SCAN_DIV - 1);
        chk_row_at(t_en + 4 * SCAN_DIV);
        pulse(4'b1010);
        chk_read("multi_data", 4'h0);
        bus_write(4'h8, 32'h0);
        pulse(4'hF);
        chk_read("dis_status", 4'h4);
        chk_state("dis");

        // Interrupt timing
        bus_write(4'h8, 32'h3);
        key_pulse = 4'b0010;
        model_push(4'b0010, cyc);
        @(negedge HCLK);
        chk("irq_pre", 32'(key_irq), 32'h0);
        @(posedge HCLK); #1;
        key_pulse = 0;
        @(negedge HCLK);
        chk("irq_post", 32'(key_irq), 32'h1);
        chk_read("irq_data", 4'h0);
        @(negedge HCLK);
        chk("irq_pop", 32'(key_irq), 32'h0);

        // Overflow and ordering
        pulse(4'b0001); pulse(4'b0010); pulse(4'b0100); pulse(4'b1000); pulse(4'b0001);
        chk_read("ovf_status", 4'h4);
        bus_write(4'h4, 32'h80);
        chk_read("ovf_cleared", 4'h4);
        repeat (4) chk_read("ovf_data", 4'h0);
        chk_read("ovf_drained", 4'h4);

        // Same-cycle push and pop on a full FIFO
        pulse(4'b0001); pulse(4'b0010); pulse(4'b0100); pulse(4'b1000);
        chk_read("pp_full", 4'h4);
        HSEL = 1; HTRANS = 2'b10; HADDR = 4'h0; HWRITE = 0;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 0;
        key_pulse = 4'b1000;
        exp = 32'h10 | 32'(q.pop_front());
        model_push(4'b1000, cyc);
        @(negedge HCLK);
        chk("pp_data", HRDATA, exp);
        @(posedge HCLK); #1;
        key_pulse = 0;
        chk_read("pp_status", 4'h4);
        repeat (4) chk_read("pp_drain", 4'h0);

        // Reset in the data phase of a DATA read
        pulse(4'b0100); pulse(4'b0001);
        HSEL = 1; HTRANS = 2'b10; HADDR = 4'h0; HWRITE = 0;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 0;
        #2 HRESETn = 0;
        #1;
        chk("mid_rst_hrdata", HRDATA, 32'h0);
        chk("mid_rst_row", 32'(row), 32'h0);
        chk("mid_rst_irq", 32'(key_irq), 32'h0);
        q.delete(); m_ovf = 0; m_en = 0; m_irq_en = 0;
        HRESETn = 1;
        @(posedge HCLK); #1;
        chk_read("post_rst_status", 4'h4);
        chk_read("post_rst_ctrl", 4'h8);

        // Randomized traffic
        bus_write(4'h8, 32'h3);
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 8))
                0, 1: pulse(4'($urandom_range(0, 15)));
                2:    chk_read("rnd_data", 4'h0);
                3:    chk_read("rnd_status", 4'h4);
                4:    bus_write(4'h4, $urandom_range(0, 1) ? 32'h80 : 32'h7F);
                5:    bus_write(4'h8, 32'($urandom_range(0, 3)));
                6:    begin
                          repeat ($urandom_range(1, 1500)) @(posedge HCLK);
                          #1;
                      end
                7:    chk_read("rnd_ctrl", 4'h8);
                default: begin
                          bus_write(4'hC, $urandom);
                          chk_read("rnd_rsvd", 4'hC);
                      end
            endcase
            chk_state("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
